// File: rtl/time_preset_editor.sv
// Interactive editor for the 2-digit BCD restart preset of the chess clock.
// Edit steps ones -> tens -> commit; up/down change the selected digit with auto-repeat.
module time_preset_editor #(
  parameter int p_BLINK_DIV    = 12_500_000,
  parameter int p_REPEAT_DELAY = 25_000_000,
  parameter int p_REPEAT_RATE  = 5_000_000,
  parameter int p_DEFAULT_TENS = 0,
  parameter int p_DEFAULT_ONES = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_edit,
  input  logic            i_cancel,
  input  logic            i_up,
  input  logic            i_down,
  output logic [1:0][3:0] o_value,
  output logic [1:0][3:0] o_edit_value,
  output logic [1:0]      o_blank,
  output logic            o_editing,
  output logic            o_commit
);

  localparam int BW  = (p_BLINK_DIV > 1) ? $clog2(p_BLINK_DIV) : 1;
  localparam int DW  = (p_REPEAT_DELAY > 1) ? $clog2(p_REPEAT_DELAY) : 1;
  localparam int RW  = (p_REPEAT_RATE > 1) ? $clog2(p_REPEAT_RATE) : 1;
  localparam int HW  = (DW > RW) ? DW : RW;

  localparam logic [BW-1:0] BLINK_LAST = BW'(p_BLINK_DIV - 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(p_REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(p_REPEAT_RATE - 1);

  localparam logic [1:0][3:0] DEFAULT_VALUE = {4'(p_DEFAULT_TENS), 4'(p_DEFAULT_ONES)};
  localparam logic [1:0][3:0] MIN_VALUE     = {4'd0, 4'd1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ONES = 2'd1;
  localparam logic [1:0] S_TENS = 2'd2;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [1:0][3:0]     value_q, value_d;
  logic [1:0][3:0]     edit_q, edit_d;
  logic                commit_q, commit_d;
  logic                editing_q, editing_d;
  logic [1:0]          blank_q, blank_d;
  logic                phase_q, phase_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;

  // Button bookkeeping, index 0 = up, 1 = down.
  logic [1:0]          prev_q, prev_d;
  logic [1:0]          armed_q, armed_d;
  logic [1:0]          rep_q, rep_d;
  logic [1:0][HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]          step;
  logic [1:0]          btn;
  logic                both;
  logic                moved;
  logic                applied;

  // A button pressed together with the other one stays disarmed until released,
  // so releasing one of a held pair never produces a step on the survivor.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    btn        = {i_down, i_up};
    both       = i_up & i_down;
    prev_d     = btn;
    armed_d    = armed_q;
    rep_d      = '0;
    hold_cnt_d = '0;
    step       = '0;
    for (int b = 0; b < 2; b++) begin
      if (!btn[b])   armed_d[b] = 1'b1;
      else if (both) armed_d[b] = 1'b0;

      if (btn[b] && !both && armed_q[b]) begin
        if (!prev_q[b]) begin
          step[b] = 1'b1;
        end else if (rep_q[b] ? (hold_cnt_q[b] == RATE_LAST) : (hold_cnt_q[b] == DELAY_LAST)) begin
          step[b]  = 1'b1;
          rep_d[b] = 1'b1;
        end else begin
          hold_cnt_d[b] = hold_cnt_q[b] + 1'b1;
          rep_d[b]      = rep_q[b];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    edit_d   = edit_q;
    commit_d = 1'b0;
    moved    = 1'b0;
    applied  = 1'b0;

    case (state_q)
      S_IDLE: if (i_edit) begin
        state_d = S_ONES;
        moved   = 1'b1;
      end
      S_ONES: if (i_cancel) begin
        state_d = S_IDLE;
        edit_d  = value_q;
        moved   = 1'b1;
      end else if (i_edit) begin
        state_d = S_TENS;
        moved   = 1'b1;
      end
      S_TENS: if (i_cancel) begin
        state_d = S_IDLE;
        edit_d  = value_q;
        moved   = 1'b1;
      end else if (i_edit) begin
        state_d  = S_IDLE;
        moved    = 1'b1;
        commit_d = 1'b1;
        // A zero preset would make the clocks expire on restart, so it becomes 01.
        if (edit_q == '0) begin
          value_d = MIN_VALUE;
          edit_d  = MIN_VALUE;
        end else begin
          value_d = edit_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        edit_d  = value_q;
      end
    endcase

    if (!moved && state_q != S_IDLE && step != 2'b00) begin
      applied = 1'b1;
      if (state_q == S_ONES) edit_d[0] = step[0] ? bcd_inc(edit_q[0]) : bcd_dec(edit_q[0]);
      else                   edit_d[1] = step[0] ? bcd_inc(edit_q[1]) : bcd_dec(edit_q[1]);
    end

    // The edited digit is shown solid right after entering a state or changing it.
    if (moved || applied || state_q == S_IDLE) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
    end

    case (state_d)
      S_ONES:  blank_d = {1'b0, phase_d};
      S_TENS:  blank_d = {phase_d, 1'b0};
      default: blank_d = 2'b00;
    endcase
    editing_d = (state_d != S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      value_q     <= DEFAULT_VALUE;
      edit_q      <= DEFAULT_VALUE;
      commit_q    <= 1'b0;
      editing_q   <= 1'b0;
      blank_q     <= 2'b00;
      phase_q     <= 1'b0;
      blink_cnt_q <= '0;
      prev_q      <= 2'b00;
      armed_q     <= 2'b11;
      rep_q       <= 2'b00;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      edit_q      <= edit_d;
      commit_q    <= commit_d;
      editing_q   <= editing_d;
      blank_q     <= blank_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      rep_q       <= rep_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign o_value      = value_q;
  assign o_edit_value = edit_q;
  assign o_blank      = blank_q;
  assign o_editing    = editing_q;
  assign o_commit     = commit_q;

endmodule

// File: doc/time_preset_editor.md
Name: time_preset_editor

Overview:
- Interactive writer of the 2-digit BCD time preset that the chess clock counters load on restart.
- Replaces the raw DIP-switch preset path.
- User steps through the ones and tens digits with an edit button and changes the selected digit with up/down buttons, which auto-repeat while held.
- Outputs the committed preset, the value being edited, per-digit blank flags for blinking the digit under edit, and a one-cycle commit pulse that downstream logic uses as a restart request.

Parameters:
p_BLINK_DIV, 12_500_000, clock cycles per blink phase (2 Hz blink at 50 MHz)
p_REPEAT_DELAY, 25_000_000, cycles a button is held after the first step before auto-repeat starts
p_REPEAT_RATE, 5_000_000, cycles between auto-repeat steps
p_DEFAULT_TENS, 0, reset value of the tens digit (0..9)
p_DEFAULT_ONES, 5, reset value of the ones digit (0..9); the two defaults must not both be 0

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-low reset
i_edit  input  1  one-cycle click pulse (debounced); enter edit / advance digit / commit
i_cancel  input  1  one-cycle click pulse; abandon the edit
i_up  input  1  debounced press level; increment the selected digit
i_down  input  1  debounced press level; decrement the selected digit
o_value  output  [3:0] x [1:0]  committed preset, BCD; [0]=ones, [1]=tens
o_edit_value  output  [3:0] x [1:0]  value shown on the display, BCD
o_blank  output  [1:0]  1 = blank the digit this cycle; [0]=ones, [1]=tens
o_editing  output  1  high in any edit state
o_commit  output  1  one-cycle pulse when a new preset is committed

Behaviour:
- Reset (i_rst=0, asynchronous):
  - o_value = o_edit_value = {p_DEFAULT_TENS, p_DEFAULT_ONES}.
  - State S_IDLE; o_blank=00, o_editing=0, o_commit=0.
  - All counters cleared.
  - Reset asserted mid-edit discards the edit.
- All outputs are registered.
- FSM states and transitions:
  - S_IDLE: i_edit -> S_ONES.
  - S_ONES: i_edit -> S_TENS; i_cancel -> S_IDLE.
  - S_TENS: i_edit -> S_IDLE with commit; i_cancel -> S_IDLE.
- o_editing = 1 in S_ONES and S_TENS.
- Commit (i_edit in S_TENS):
  - On the next edge, o_value <= o_edit_value and o_commit=1 for exactly one cycle.
  - If the edit value is 00, both o_value and o_edit_value are forced to 01.
- Cancel:
  - o_edit_value <= o_value, no o_commit.
  - i_cancel and i_edit in the same cycle: cancel wins.
  - i_cancel in S_IDLE is ignored.
- Step generation, done independently for up and down:
  - Register the previous level of each button.
  - A rising edge gives one step on the following edge.
  - While the button stays held, a hold counter runs. At p_REPEAT_DELAY cycles after the first step, a second step occurs, then one step every p_REPEAT_RATE cycles.
  - Release clears the hold counter.
  - If i_up and i_down are both high, no steps are generated and both hold counters are held at 0. When one button is released, the one still held does not step until its next rising edge.
- Digit arithmetic:
  - Only the selected digit changes (ones in S_ONES, tens in S_TENS).
  - Up: 9 -> 0 wrap. Down: 0 -> 9 wrap.
  - No carry or borrow between digits.
  - Steps in S_IDLE are ignored.
  - On a cycle where an FSM transition occurs, any step is dropped.
- Blink:
  - A phase counter counts to p_BLINK_DIV-1 and toggles a phase bit, only in the edit states.
  - The selected digit's o_blank bit = phase; the other bit = 0.
  - Phase and counter reset to 0 (digit visible) on entering any edit state and on every applied step.
  - In S_IDLE, o_blank = 00.
- Counter widths: $clog2 of the respective parameter; each counter saturates or reloads and never wraps past its terminal count.

Test Plan:
(Use p_BLINK_DIV=4, p_REPEAT_DELAY=10, p_REPEAT_RATE=3.)
1. Reset, then release -> o_value=o_edit_value=05, o_blank=00, o_editing=0, o_commit=0. Assert i_rst mid-edit -> the same values immediately, asynchronously.
2. Edit; 3 single up clicks on ones; edit; 2 down clicks on tens (0 -> 9 -> 8); edit -> o_value=88, o_commit high exactly 1 cycle, o_editing=0.
3. Edit from 05; hold i_up for 20 cycles -> steps at cycle 1, 11, 14, 17, 20 (5 steps, ones 5 -> 0 wrap). Tens unchanged. o_blank[0] stays low for 4 cycles after each step.
4. Edit, change ones to 7, then i_cancel -> o_edit_value=05, o_value=05, no o_commit. Same-cycle i_edit+i_cancel in S_TENS -> cancel behaviour, no commit.
5. Set the edit value to 00 and commit -> o_value=01, o_edit_value=01, o_commit pulse.
6. In S_ONES, hold i_up and i_down together for 15 cycles -> no change. Release i_down -> no step. Re-press i_up -> 1 step. In S_IDLE, i_up -> no change.
